// File: rtl/instr_fetch_seq.sv
// rtl/instr_fetch_seq.sv - PC ownership, instruction fetch handshake and sequencing for the lab CPU.
// Optional fetch timeout enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_seq #(
  parameter int ADDR_W  = 8,
  parameter int IMM_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [3:0]        op,
  output logic [15:0]       instr,
  output logic              instr_valid,
  input  logic              branch,
  input  logic              jump,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       retired,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_next;

  assign imem_addr = pc;
  assign op        = instr[15:12];
  assign br_off    = ADDR_W'($signed(instr[IMM_W-1:0]));

  // Jump outranks branch; all arithmetic wraps at the PC width.
  always_comb begin
    if (jump) begin
      pc_next = instr[ADDR_W-1:0];
    end else if (branch) begin
      pc_next = pc + ADDR_W'(1) + br_off;
    end else begin
      pc_next = pc + ADDR_W'(1);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Counts ack-less FETCH cycles; cleared whenever we are outside FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != FETCH) begin
      tmo_cnt <= '0;
    end else if (!imem_ack && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign fetch_err = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired     <= '0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_data;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (tmo_hit) begin
            imem_req  <= 1'b0;
            fetch_err <= 1'b1;
            halted    <= 1'b1;
            state     <= HALT;
          end
`endif
        end
        EXEC: begin
          if (!stall) begin
            instr_valid <= 1'b0;
            if (retired != 16'hFFFF) begin
              retired <= retired + 16'd1;
            end
            if (op == 4'hF) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc <= pc_next;
              if (run) begin
                state    <= FETCH;
                imem_req <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          halted      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
